// File: rtl/light_encoder_7seg_pkg.sv
// Shared constants for the LED / switch / 7-segment demo block.
package light_encoder_7seg_pkg;

  localparam logic [7:0]  SEG_BLANK   = 8'hFF;
  localparam logic [15:0] LIGHT_RESET = 16'h0001;

  // Active-low segments, bit0=a .. bit6=g, bit7=dp (kept off); entry n is digit n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/light_encoder_7seg_bcd7seg.sv
// Registered hex-to-7-segment decoder with blanking enable.
module bcd7seg
  import light_encoder_7seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       en,
  output logic [7:0] hex
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hex <= SEG_BLANK;
    else      hex <= en ? SEG_TABLE[num] : SEG_BLANK;
  end

endmodule

// File: rtl/light_encoder_7seg_encoder83.sv
// Registered 8-to-3 priority encoder; highest set request wins, 0 when idle or disabled.
module encoder83 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic       en,
  output logic [2:0] y
);

  logic [2:0] pri;

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    pri = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) pri = 3'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y <= '0;
    else      y <= en ? pri : 3'd0;
  end

endmodule

// File: rtl/light_encoder_7seg_light.sv
// Running light: one lit LED rotating left once every LIGHT_DIV cycles.
module light
  import light_encoder_7seg_pkg::*;
#(
  parameter int LIGHT_DIV = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] led
);

  localparam int            CW   = $clog2(LIGHT_DIV);
  localparam logic [CW-1:0] LAST = CW'(LIGHT_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      led <= LIGHT_RESET;
    end else if (cnt == LAST) begin
      cnt <= '0;
      led <= {led[14:0], led[15]};
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/light_encoder_7seg.sv
// Board demo: running light on ledr, switch priority encoder shown on seg0.
module light_encoder_7seg
  import light_encoder_7seg_pkg::*;
#(
  parameter int LIGHT_DIV = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  sw,
  output logic [15:0] ledr,
  output logic [7:0]  seg0
);

  logic [2:0] y;

  light #(.LIGHT_DIV(LIGHT_DIV)) u_light (
    .clk (clk),
    .rst (rst),
    .led (ledr)
  );

  encoder83 u_enc (
    .clk (clk),
    .rst (rst),
    .x   (sw[7:0]),
    .en  (sw[8]),
    .y   (y)
  );

  bcd7seg u_seg (
    .clk (clk),
    .rst (rst),
    .num ({1'b0, y}),
    .en  (sw[9]),
    .hex (seg0)
  );

endmodule

// File: tb/tb_light_encoder_7seg.sv
// Directed bench with an expected-value queue for seg0 and a shift-count model for ledr.
module tb_light_encoder_7seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sw;
  logic [15:0] ledr;
  logic [7:0]  seg0;
  logic [3:0]  dnum;
  logic        den;
  logic [7:0]  dhex;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tbl [16];

  light_encoder_7seg #(.LIGHT_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .ledr (ledr),
    .seg0 (seg0)
  );

  bcd7seg u_dec (
    .clk (clk),
    .rst (rst),
    .num (dnum),
    .en  (den),
    .hex (dhex)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_seg(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s scoreboard empty obs=%h", tag, seg0);
    end else begin
      e = exp_q.pop_front();
      total++;
      assert (seg0 === e) else begin
        bad++;
        $error("FAIL %s seg0 obs=%h exp=%h", tag, seg0, e);
      end
    end
  endtask

  task automatic chk_led(input string tag, input logic [15:0] e);
    total++;
    assert (ledr === e) else begin
      bad++;
      $error("FAIL %s ledr obs=%h exp=%h", tag, ledr, e);
    end
  endtask

  initial begin
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst = 1'b0; sw = '0; dnum = '0; den = 1'b0;

    // reset state
    step(3);
    chk_led("rst_led", 16'h0001);
    exp_q.push_back(8'hFF); chk_seg("rst_seg");

    // release and walk the light through a full wrap
    rst = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      logic [15:0] e;
      step(1);
      e = 16'h0001 << ((i / 4) % 16);
      chk_led($sformatf("light_%0d", i), e);
      total++;
      assert ($countones(ledr) == 1) else begin
        bad++;
        $error("FAIL onehot_%0d ledr obs=%h exp=one bit", i, ledr);
      end
    end
    exp_q.push_back(8'hFF); chk_seg("idle_blank");

    // priority: highest request 7; first edge still shows the old y (0)
    sw = 10'b11_1010_0101;
    exp_q.push_back(8'hC0); exp_q.push_back(8'hF8);
    step(1); chk_seg("prio7_lat1");
    step(1); chk_seg("prio7");
    sw[7:0] = 8'h06;
    exp_q.push_back(8'hA4);
    step(2); chk_seg("prio2");

    // encoder disabled
    sw = {2'b10, 8'hFF};
    exp_q.push_back(8'hC0);
    step(2); chk_seg("enc_off");
    // display disabled: one cycle
    sw[9] = 1'b0;
    exp_q.push_back(8'hFF);
    step(1); chk_seg("disp_off");
    // no requests
    sw = {2'b11, 8'h00};
    exp_q.push_back(8'hC0);
    step(2); chk_seg("no_req");

    // walking one sweep
    for (int k = 0; k < 8; k++) begin
      sw = {2'b11, 8'(1 << k)};
      exp_q.push_back(tbl[k]);
      step(2); chk_seg($sformatf("sweep_%0d", k));
    end

    // decoder unit: full 4-bit decode, dp always off
    den = 1'b1;
    for (int n = 0; n < 16; n++) begin
      dnum = 4'(n);
      step(1);
      total++;
      assert (dhex === tbl[n] && dhex[7] === 1'b1) else begin
        bad++;
        $error("FAIL dec_%0d hex obs=%h exp=%h", n, dhex, tbl[n]);
      end
    end

    // mid-operation asynchronous reset
    rst = 1'b0;
    sw = {2'b11, 8'h80};
    step(2);
    rst = 1'b1;
    step(16);
    chk_led("pre_rst_led", 16'h0010);
    exp_q.push_back(8'hF8); chk_seg("pre_rst_seg");
    #3 rst = 1'b0;
    #1;
    chk_led("async_led", 16'h0001);
    exp_q.push_back(8'hFF); chk_seg("async_seg");
    step(1);
    rst = 1'b1;
    step(3); chk_led("post_rst_3", 16'h0001);
    step(1); chk_led("post_rst_4", 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
